muldiv_unit: RTL and testbench

- Iterative RV64M multiply/divide execution unit in the EX stage, beside the single-cycle ALU.
- Accepts one operation at a time from the ID/EX issue logic through a valid/ready request port.
- Computes over multiple cycles and returns the result through a valid/ready response port toward EX/MEM writeback.
- Pipeline stalls while busy is high; flush aborts in-flight work.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_sign_fix.sv | 44 ++++
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

    localparam int MD_DATA_W = 64;
    localparam int MD_CNT_W  = $clog2(MD_DATA_W) + 1;
    localparam logic [MD_DATA_W-1:0] MD_MOST_NEG = {1'b1, {(MD_DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude / result sign selection for PREP, and the final conditional
// two's-complement negate for FIX.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int W = MD_DATA_W
) (
    input  muldiv_op_t     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   abs_a,
    output logic [W-1:0]   abs_b,
    output logic           res_neg,
    input  logic [2*W-1:0] fix_in,
    input  logic           fix_neg,
    output logic [2*W-1:0] fix_out
);

    always_comb begin
        abs_a   = a;
        abs_b   = b;
        res_neg = 1'b0;
        case (op)
            OP_MULH, OP_DIV: begin
                abs_a   = a[W-1] ? -a : a;
                abs_b   = b[W-1] ? -b : b;
                res_neg = a[W-1] ^ b[W-1];
            end
            OP_MULHSU: begin
                abs_a   = a[W-1] ? -a : a;
                res_neg = a[W-1];
            end
            OP_REM: begin
                abs_a   = a[W-1] ? -a : a;
                abs_b   = b[W-1] ? -b : b;
                res_neg = a[W-1];
            end
            default: ;
        endcase
        // MUL low half is sign-agnostic, so it stays unsigned with res_neg=0.
        fix_out = fix_neg ? -fix_in : fix_in;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide: one bit per cycle shift-add multiply and
// restoring divide, valid/ready request and response, flush aborts in-flight work.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    muldiv_state_t       state;
    muldiv_op_t          op_q;
    logic [DATA_W-1:0]   a_q, b_q, opnd, sreg;
    logic [2*DATA_W-1:0] acc;
    logic [TAG_W-1:0]    tag_q;
    logic [CNT_W-1:0]    cnt;
    logic                neg_q, special;

    logic [DATA_W-1:0]   abs_a, abs_b, special_res, result;
    logic                res_neg, is_div, b_zero, ovf;
    logic [2*DATA_W-1:0] fix_in, fix_out, mul_next;
    logic [DATA_W:0]     trial;

    muldiv_sign_fix #(.W(DATA_W)) u_sign_fix (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .abs_a   (abs_a),
        .abs_b   (abs_b),
        .res_neg (res_neg),
        .fix_in  (fix_in),
        .fix_neg (neg_q & ~special),
        .fix_out (fix_out)
    );

    always_comb begin
        is_div      = op_q[2];
        b_zero      = (b_q == '0);
        ovf         = (op_q == OP_DIV || op_q == OP_REM) && (a_q == MOST_NEG) && (&b_q);
        special_res = (op_q == OP_DIV || op_q == OP_DIVU) ? (b_zero ? '1 : a_q)
                                                          : (b_zero ? a_q : '0);
        // sreg carries the multiplier bits (mul) or dividend bits then quotient (div).
        trial       = {acc[DATA_W-1:0], sreg[DATA_W-1]} - {1'b0, opnd};
        mul_next    = {acc[2*DATA_W-2:0], 1'b0}
                    + (sreg[DATA_W-1] ? {{DATA_W{1'b0}}, opnd} : '0);
        if (special) begin
            fix_in = {{DATA_W{1'b0}}, acc[DATA_W-1:0]};
        end else begin
            case (op_q)
                OP_DIV, OP_DIVU: fix_in = {{DATA_W{1'b0}}, sreg};
                OP_REM, OP_REMU: fix_in = {{DATA_W{1'b0}}, acc[DATA_W-1:0]};
                default:         fix_in = acc;
            endcase
        end
        if (!special && (op_q == OP_MULH || op_q == OP_MULHSU || op_q == OP_MULHU))
            result = fix_out[2*DATA_W-1:DATA_W];
        else
            result = fix_out[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_tag   <= '0;
        end else if (flush) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid && req_ready) begin
                    op_q      <= muldiv_op_t'(req_op);
                    a_q       <= req_a;
                    b_q       <= req_b;
                    tag_q     <= req_tag;
                    req_ready <= 1'b0;
                    busy      <= 1'b1;
                    state     <= S_PREP;
                end
                S_PREP: begin
                    neg_q   <= res_neg;
                    cnt     <= CNT_W'(DATA_W);
                    opnd    <= is_div ? abs_b : abs_a;
                    sreg    <= is_div ? abs_a : abs_b;
                    special <= 1'b0;
                    acc     <= '0;
                    // Special divides park their answer in acc and take FIX straight
                    // away, giving a two-cycle accept-to-response turnaround.
                    if (is_div && (b_zero || ovf)) begin
                        special <= 1'b1;
                        acc     <= {{DATA_W{1'b0}}, special_res};
                        state   <= S_FIX;
                    end else begin
                        state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        acc[DATA_W-1:0] <= trial[DATA_W] ? {acc[DATA_W-2:0], sreg[DATA_W-1]}
                                                         : trial[DATA_W-1:0];
                        sreg <= {sreg[DATA_W-2:0], ~trial[DATA_W]};
                    end else begin
                        acc  <= mul_next;
                        sreg <= {sreg[DATA_W-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= S_FIX;
                end
                S_FIX: begin
                    resp_data  <= result;
                    resp_tag   <= tag_q;
                    resp_valid <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV64M cases plus randomized operations
// checked against a plain-arithmetic reference model; a monitor pops and compares.
module tb_muldiv_unit;

    localparam int W = 64;
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk = 1'b0;
    logic         reset, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
    logic [2:0]   req_op;
    logic [W-1:0] req_a, req_b, resp_data;
    logic [4:0]   req_tag, resp_tag;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_W(W), .TAG_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        int          acc_cyc;
        int          lat;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        int          lat;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t dv[13];
    int   checks = 0, failures = 0, cyc = 0;
    bit   seen = 0, rand_rdy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (rand_rdy) resp_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: RISC-V M-extension semantics using wide plain arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic signed [127:0] sa, sb, sub;
        logic [127:0]        p;
        logic signed [63:0]  qa, qb;
        sa  = {{64{a[63]}}, a};
        sb  = {{64{b[63]}}, b};
        sub = {64'd0, b};
        qa  = a;
        qb  = b;
        case (op)
            3'd0: begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
            3'd1: begin p = sa * sb; return p[127:64]; end
            3'd2: begin p = sa * sub; return p[127:64]; end
            3'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
            3'd4: begin
                if (b == 0) return ONES;
                if (a == MIN && b == ONES) return MIN;
                return qa / qb;
            end
            3'd5: return (b == 0) ? ONES : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == ONES) return 64'd0;
                return qa % qb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [63:0] a,
                                   input logic [63:0] b);
        if (op >= 3'd4 && (b == 0 || ((op == 3'd4 || op == 3'd6) && a == MIN && b == ONES)))
            return 2;
        return 66;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag, input logic [63:0] res, input int lat,
                         input bit track);
        int   n;
        exp_t e;
        n = 0;
        while (!req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout req_ready=%b required=1", req_ready);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (track) begin
            e.data    = res;
            e.tag     = tag;
            e.acc_cyc = cyc;
            e.lat     = lat;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || resp_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0 || resp_valid) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return ONES;
            2:       return MIN;
            3:       return 64'($urandom_range(0, 20));
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Monitor: compare each response once, on its first valid cycle.
    always @(negedge clk) begin
        if (reset) begin
            seen = 0;
        end else begin
            if (resp_valid && !seen) begin
                seen = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp data=%h tag=%0d required=none", resp_data, resp_tag);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_data", resp_data, mon_e.data);
                    chk("resp_tag", 64'(resp_tag), 64'(mon_e.tag));
                    chk("latency", 64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
                end
            end
            if (resp_valid && resp_ready) seen = 0;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [63:0] a, b;
        logic [4:0]  tag;
        int          n;

        reset = 1; flush = 0; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; req_tag = 0;
        resp_ready = 1;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_resp_data", resp_data, 64'd0);
        chk("reset_resp_tag", 64'(resp_tag), 64'd0);
        reset = 0;

        dv[0]  = '{3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66};
        dv[1]  = '{3'd3, ONES, 64'd2, 64'd1, 66};
        dv[2]  = '{3'd1, ONES, 64'd2, ONES, 66};
        dv[3]  = '{3'd2, ONES, 64'd2, ONES, 66};
        dv[4]  = '{3'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66};
        dv[5]  = '{3'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66};
        dv[6]  = '{3'd5, 64'd20, 64'd3, 64'd6, 66};
        dv[7]  = '{3'd7, 64'd20, 64'd3, 64'd2, 66};
        dv[8]  = '{3'd4, 64'd5, 64'd0, ONES, 2};
        dv[9]  = '{3'd7, 64'd5, 64'd0, 64'd5, 2};
        dv[10] = '{3'd4, MIN, ONES, MIN, 2};
        dv[11] = '{3'd6, MIN, ONES, 64'd0, 2};
        dv[12] = '{3'd1, MIN, MIN, 64'h4000_0000_0000_0000, 66};
        for (int i = 0; i < 13; i++)
            issue(dv[i].op, dv[i].a, dv[i].b, 5'(i + 3), dv[i].res, dv[i].lat, 1'b1);
        drain();

        // Randomized operations under random response back-pressure.
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = pick();
            b   = pick();
            tag = 5'($urandom_range(0, 31));
            issue(op, a, b, tag, model(op, a, b), exp_lat(op, a, b), 1'b1);
        end
        rand_rdy = 0;
        @(negedge clk);
        resp_ready = 1;
        drain();

        // Held back-pressure in DONE.
        @(negedge clk);
        resp_ready = 0;
        issue(3'd5, 64'd100, 64'd7, 5'd17, 64'd14, 66, 1'b1);
        n = 0;
        while (!resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 64'(resp_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(resp_valid), 64'd1);
            chk("bp_hold_data", resp_data, 64'd14);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1;
        @(negedge clk);
        chk("bp_release_valid", 64'(resp_valid), 64'd0);
        chk("bp_release_ready", 64'(req_ready), 64'd1);
        chk("bp_release_busy", 64'(busy), 64'd0);

        // A request presented together with flush must be ignored.
        flush = 1; req_valid = 1; req_op = 3'd0; req_a = 64'd9; req_b = 64'd9;
        @(negedge clk);
        flush = 0; req_valid = 0;
        chk("flush_req_busy", 64'(busy), 64'd0);
        chk("flush_req_ready", 64'(req_ready), 64'd1);

        // Flush in the middle of CALC, then a fresh multiply.
        issue(3'd0, 64'd5, 64'd6, 5'd9, 64'd0, 0, 1'b0);
        repeat (31) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_req_ready2", 64'(req_ready), 64'd1);
        chk("flush_resp_valid", 64'(resp_valid), 64'd0);
        issue(3'd0, 64'd3, 64'd4, 5'd21, 64'd12, 66, 1'b1);
        drain();

        // Same abort via reset: everything returns to reset values.
        issue(3'd0, 64'd9, 64'd9, 5'd30, 64'd0, 0, 1'b0);
        repeat (31) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("rst_abort_req_ready", 64'(req_ready), 64'd1);
        chk("rst_abort_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_abort_busy", 64'(busy), 64'd0);
        chk("rst_abort_resp_data", resp_data, 64'd0);
        chk("rst_abort_resp_tag", 64'(resp_tag), 64'd0);
        reset = 0;
        @(negedge clk);
        issue(3'd7, 64'd23, 64'd5, 5'd2, 64'd3, 66, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
